// File: rtl/spec_payload_serializer.sv
// Serializes whole spectra popped from pre_data_buffer into a byte stream,
// prefixed by a 4-byte big-endian sequence header per packet of N_SPECS spectra.
module spec_payload_serializer #(
    parameter int unsigned N           = 8,
    parameter int unsigned DATA_POINTS = 5,
    parameter int unsigned N_SPECS     = 3
) (
    input  logic          eth_clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [N-1:0]  buf_data [DATA_POINTS],
    input  logic          buf_rvalid,
    input  logic          buf_empty,
    output logic          buf_rready,
    output logic [7:0]    m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          m_tlast,
    output logic [31:0]   pkt_seq,
    output logic          busy
);

    localparam int unsigned B  = N / 8;
    localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned PW = (DATA_POINTS > 1) ? $clog2(DATA_POINTS) : 1;
    localparam int unsigned SW = (N_SPECS > 1) ? $clog2(N_SPECS) : 1;
    localparam bit ONE_BYTE_SPEC = (B == 1) && (DATA_POINTS == 1);

    typedef enum logic [1:0] {IDLE, HEADER, FETCH, STREAM} state_t;

    state_t         state_q, state_d;
    logic [1:0]     hdr_q, hdr_d;
    logic [BW-1:0]  byte_q, byte_d;
    logic [PW-1:0]  pt_q, pt_d;
    logic [SW-1:0]  spec_q, spec_d;
    logic [N-1:0]   shadow_q [DATA_POINTS];
    logic [N-1:0]   shadow_d [DATA_POINTS];
    logic           buf_rready_d;
    logic [7:0]     m_tdata_d;
    logic           m_tvalid_d;
    logic           m_tlast_d;
    logic [31:0]    pkt_seq_d;
    logic           busy_d;
    logic           xfer;
    logic [BW-1:0]  nb;
    logic [PW-1:0]  np;

    // Byte idx of a data word, MSB byte first.
    function automatic logic [7:0] word_byte(input logic [N-1:0] w, input logic [BW-1:0] idx);
        int unsigned sa;
        logic [N-1:0] sh;
        sa = 8 * (B - 1 - 32'(idx));
        sh = w >> sa;
        return sh[7:0];
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [31:0] seq, input logic [1:0] idx);
        logic [31:0] sh;
        sh = seq >> (8 * (3 - 32'(idx)));
        return sh[7:0];
    endfunction

    assign xfer = m_tvalid && m_tready;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        byte_d       = byte_q;
        pt_d         = pt_q;
        spec_d       = spec_q;
        shadow_d     = shadow_q;
        buf_rready_d = buf_rready;
        m_tdata_d    = m_tdata;
        m_tvalid_d   = m_tvalid;
        m_tlast_d    = m_tlast;
        pkt_seq_d    = pkt_seq;
        nb           = '0;
        np           = '0;

        case (state_q)
            IDLE: begin
                if (enable && !buf_empty) begin
                    state_d    = HEADER;
                    hdr_d      = 2'd0;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    m_tdata_d  = hdr_byte(pkt_seq, 2'd0);
                end
            end
            HEADER: begin
                if (xfer) begin
                    if (hdr_q == 2'd3) begin
                        state_d      = FETCH;
                        m_tvalid_d   = 1'b0;
                        buf_rready_d = 1'b1;
                    end else begin
                        hdr_d     = hdr_q + 2'd1;
                        m_tdata_d = hdr_byte(pkt_seq, hdr_q + 2'd1);
                    end
                end
            end
            FETCH: begin
                if (buf_rvalid && buf_rready) begin
                    shadow_d     = buf_data;
                    buf_rready_d = 1'b0;
                    state_d      = STREAM;
                    byte_d       = '0;
                    pt_d         = '0;
                    m_tvalid_d   = 1'b1;
                    m_tdata_d    = word_byte(buf_data[0], '0);
                    m_tlast_d    = ONE_BYTE_SPEC && (spec_q == SW'(N_SPECS - 1));
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (byte_q == BW'(B - 1) && pt_q == PW'(DATA_POINTS - 1)) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        if (spec_q == SW'(N_SPECS - 1)) begin
                            state_d   = IDLE;
                            spec_d    = '0;
                            pkt_seq_d = pkt_seq + 32'd1;
                        end else begin
                            state_d      = FETCH;
                            spec_d       = spec_q + SW'(1);
                            buf_rready_d = 1'b1;
                        end
                    end else begin
                        if (byte_q == BW'(B - 1)) begin
                            nb = '0;
                            np = pt_q + PW'(1);
                        end else begin
                            nb = byte_q + BW'(1);
                            np = pt_q;
                        end
                        byte_d    = nb;
                        pt_d      = np;
                        m_tdata_d = word_byte(shadow_q[np], nb);
                        m_tlast_d = (spec_q == SW'(N_SPECS - 1)) && (nb == BW'(B - 1))
                                    && (np == PW'(DATA_POINTS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hdr_q      <= '0;
            byte_q     <= '0;
            pt_q       <= '0;
            spec_q     <= '0;
            for (int i = 0; i < int'(DATA_POINTS); i++) shadow_q[i] <= '0;
            buf_rready <= 1'b0;
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            pkt_seq    <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            byte_q     <= byte_d;
            pt_q       <= pt_d;
            spec_q     <= spec_d;
            shadow_q   <= shadow_d;
            buf_rready <= buf_rready_d;
            m_tdata    <= m_tdata_d;
            m_tvalid   <= m_tvalid_d;
            m_tlast    <= m_tlast_d;
            pkt_seq    <= pkt_seq_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_spec_payload_serializer.sv
// Bench for spec_payload_serializer: buffer model, byte scoreboard, stall/reset corners.
module tb_spec_payload_serializer;

    localparam int unsigned DP = 5;

    logic        eth_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  buf_data [DP];
    logic        buf_rvalid, buf_empty, buf_rready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] pkt_seq;
    logic        busy;

    logic        en2;
    logic [15:0] b2_data [2];
    logic        b2_rvalid, b2_empty, b2_rready;
    logic [7:0]  m2_tdata;
    logic        m2_tvalid, m2_tready, m2_tlast;
    logic [31:0] pkt_seq2;
    logic        busy2;

    always #5 eth_clk = ~eth_clk;

    spec_payload_serializer u_dut (
        .eth_clk(eth_clk), .rst_n(rst_n), .enable(enable), .buf_data(buf_data),
        .buf_rvalid(buf_rvalid), .buf_empty(buf_empty), .buf_rready(buf_rready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .pkt_seq(pkt_seq), .busy(busy)
    );

    spec_payload_serializer #(.N(16), .DATA_POINTS(2), .N_SPECS(1)) u_dut16 (
        .eth_clk(eth_clk), .rst_n(rst_n), .enable(en2), .buf_data(b2_data),
        .buf_rvalid(b2_rvalid), .buf_empty(b2_empty), .buf_rready(b2_rready),
        .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tready(m2_tready), .m_tlast(m2_tlast),
        .pkt_seq(pkt_seq2), .busy(busy2)
    );

    typedef struct { logic [7:0] data; logic last; } exp_t;
    typedef struct {
        bit toggle; bit stall; bit drop_en; bit vary;
        int load_pk; int exp_pk; int exp_bytes; int exp_pops; int exp_seq;
    } vec_t;

    exp_t         exp_q [$];
    logic [39:0]  wq [$];
    int           errors = 0, checks = 0;
    int           byte_cnt, tlast_cnt, pops, rr_pulses, stall_left;
    bit           pop_now, prev_stall, prev_rr, tog, stall_en, in_stall;
    logic [7:0]   prev_data;
    logic         prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] word_of(input int p, input int s, input bit vary);
        logic [7:0] k;
        k = vary ? 8'((p * 3 + s) * 17 + 1) : 8'h00;
        return 40'hc0ffee0ff0 ^ {5{k}};
    endfunction

    task automatic push_packet(input int p, input bit vary, input logic [31:0] seq);
        logic [39:0] w;
        for (int h = 0; h < 4; h++) exp_q.push_back('{8'(seq >> (8 * (3 - h))), 1'b0});
        for (int s = 0; s < 3; s++) begin
            w = word_of(p, s, vary);
            for (int k = 0; k < 5; k++)
                exp_q.push_back('{w[8*(4-k) +: 8], (s == 2 && k == 4)});
        end
    endtask

    task automatic clear_state();
        wq.delete(); exp_q.delete();
        byte_cnt = 0; tlast_cnt = 0; pops = 0; rr_pulses = 0;
        pop_now = 0; prev_stall = 0; prev_rr = 0; in_stall = 0; stall_left = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0;
        clear_state();
        repeat (2) @(negedge eth_clk);
        @(posedge eth_clk); #1 rst_n = 1'b1;
    endtask

    // Output monitor: scoreboard pops, hold-while-stalled, rready pulse count
    always @(negedge eth_clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_tvalid), 32'd1);
                check("hold_data", 32'(m_tdata), 32'(prev_data));
                check("hold_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(m_tdata), 32'hxxxx_dead);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("byte_data", 32'(m_tdata), 32'(e.data));
                    check("byte_last", 32'(m_tlast), 32'(e.last));
                end
                byte_cnt++;
                if (m_tlast) tlast_cnt++;
            end
            if (buf_rready && !prev_rr) rr_pulses++;
            prev_rr    = buf_rready;
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            pop_now    = buf_rvalid && buf_rready;
        end
    end

    // Buffer model and downstream ready driver
    always @(posedge eth_clk) begin
        #1;
        if (pop_now && wq.size() > 0) begin
            void'(wq.pop_front());
            pops++;
        end
        pop_now = 0;
        m_tready = tog ? ~m_tready : 1'b1;
        if (stall_en && pops == 1 && stall_left > 0) begin
            stall_left--;
            in_stall = 1;
        end else begin
            in_stall = 0;
        end
        buf_empty  = (wq.size() == 0);
        buf_rvalid = !buf_empty && !in_stall;
        for (int k = 0; k < int'(DP); k++)
            buf_data[k] = (wq.size() > 0) ? wq[0][8*(DP-1-k) +: 8] : 8'h00;
    end

    initial begin
        vec_t tbl [4];
        vec_t v;
        logic [7:0] exp2 [8];
        int idx, cyc;
        bit done, pop2;

        tbl[0] = '{0, 0, 0, 0, 1, 1, 19, 3, 1};
        tbl[1] = '{1, 0, 0, 0, 1, 1, 19, 3, 1};
        tbl[2] = '{0, 1, 0, 0, 1, 1, 19, 3, 1};
        tbl[3] = '{0, 0, 1, 1, 3, 2, 38, 6, 2};

        tog = 0; stall_en = 0; m_tready = 1'b1; enable = 1'b0;
        buf_empty = 1'b1; buf_rvalid = 1'b0;
        for (int k = 0; k < int'(DP); k++) buf_data[k] = 8'h00;
        en2 = 1'b0; b2_rvalid = 1'b0; b2_empty = 1'b1; m2_tready = 1'b1;
        b2_data[0] = 16'h1234; b2_data[1] = 16'habcd;
        rst_n = 1'b1;
        clear_state();
        #12;
        // Async reset with no clock edge between assertion and check
        rst_n = 1'b0;
        #2;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_rready", 32'(buf_rready), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_seq", pkt_seq, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        do_reset();

        for (int t = 0; t < 4; t++) begin
            v = tbl[t];
            do_reset();
            tog = v.toggle; stall_en = v.stall; stall_left = v.stall ? 20 : 0;
            m_tready = 1'b1;
            for (int p = 0; p < v.load_pk; p++)
                for (int s = 0; s < 3; s++) wq.push_back(word_of(p, s, v.vary));
            for (int p = 0; p < v.exp_pk; p++) push_packet(p, v.vary, 32'(p));
            enable = 1'b1;
            done = 0;
            for (cyc = 0; cyc < 2000 && !done; cyc++) begin
                @(negedge eth_clk);
                if (v.drop_en && byte_cnt >= 20) enable = 1'b0;
                if (v.stall && in_stall && stall_left == 0) begin
                    check("stall_rready", 32'(buf_rready), 32'd1);
                    check("stall_tvalid", 32'(m_tvalid), 32'd0);
                end
                if (exp_q.size() == 0 && !busy) done = 1;
            end
            if (!done) check("timeout", 32'(cyc), 32'd0);
            repeat (10) @(negedge eth_clk);
            check("byte_count", 32'(byte_cnt), 32'(v.exp_bytes));
            check("tlast_count", 32'(tlast_cnt), 32'(v.exp_pk));
            check("seq_after", pkt_seq, 32'(v.exp_seq));
            check("pops", 32'(pops), 32'(v.exp_pops));
            check("rready_pulses", 32'(rr_pulses), 32'(v.exp_pops));
            check("words_left", 32'(wq.size()), 32'(v.load_pk * 3 - v.exp_pops));
            check("idle_busy", 32'(busy), 32'd0);
        end
        tog = 0; stall_en = 0;

        // Mid-packet reset: resume with leftover words, then abort inside the stream
        push_packet(2, 1'b1, 32'd2);
        enable = 1'b1;
        done = 0;
        for (cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge eth_clk);
            if (byte_cnt >= 46) done = 1;
        end
        if (!done) check("mid_timeout", 32'(cyc), 32'd0);
        check("mid_seq_before", pkt_seq, 32'd2);
        check("mid_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(m_tlast), 32'd0);
        check("mid_rst_seq", pkt_seq, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        do_reset();

        // 16-bit, 2-point, 1-spectrum instance
        exp2 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'hab, 8'hcd};
        en2 = 1'b1; b2_empty = 1'b0; b2_rvalid = 1'b1;
        idx = 0; pop2 = 0;
        for (cyc = 0; cyc < 100 && idx < 8; cyc++) begin
            @(negedge eth_clk);
            if (m2_tvalid && m2_tready) begin
                check("w16_data", 32'(m2_tdata), 32'(exp2[idx]));
                check("w16_last", 32'(m2_tlast), 32'(idx == 7));
                idx++;
            end
            if (b2_rvalid && b2_rready) pop2 = 1;
            @(posedge eth_clk); #1;
            if (pop2) begin b2_rvalid = 1'b0; b2_empty = 1'b1; end
        end
        en2 = 1'b0;
        repeat (3) @(negedge eth_clk);
        check("w16_count", 32'(idx), 32'd8);
        check("w16_seq", pkt_seq2, 32'd1);
        check("w16_busy", 32'(busy2), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
